// File: rtl/wb_uart_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of a single wb2uart bridge.
// One transaction at a time: IDLE -> BUSY (until ack or timeout) -> GAP -> IDLE.
module wb_uart_arbiter #(
  parameter int addr_width     = 32,
  parameter int data_width     = 32,
  parameter int sel_width      = data_width / 8,
  parameter int timeout_cycles = 100000,
  parameter int counter_width  = $clog2(timeout_cycles + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  m0_cyc,
  input  logic                  m0_stb,
  input  logic                  m0_we,
  input  logic [addr_width-1:0] m0_adr,
  input  logic [data_width-1:0] m0_datwr,
  input  logic [sel_width-1:0]  m0_sel,
  output logic                  m0_ack,
  output logic                  m0_err,
  output logic [data_width-1:0] m0_datrd,
  input  logic                  m1_cyc,
  input  logic                  m1_stb,
  input  logic                  m1_we,
  input  logic [addr_width-1:0] m1_adr,
  input  logic [data_width-1:0] m1_datwr,
  input  logic [sel_width-1:0]  m1_sel,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic [data_width-1:0] m1_datrd,
  output logic                  s_cyc,
  output logic                  s_stb,
  output logic                  s_we,
  output logic [addr_width-1:0] s_adr,
  output logic [data_width-1:0] s_datwr,
  output logic [sel_width-1:0]  s_sel,
  input  logic                  s_ack,
  input  logic [data_width-1:0] s_datrd,
  output logic                  s_abort,
  output logic                  busy,
  output logic                  owner
);

  localparam int CNT_W = (counter_width > 0) ? counter_width : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((timeout_cycles > 0) ? timeout_cycles - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req0, req1, win, grant, timeout_hit;
  logic             vld_p1;

  logic                  we_p1;
  logic [addr_width-1:0] adr_p1;
  logic [data_width-1:0] datwr_p1;
  logic [sel_width-1:0]  sel_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign req0 = m0_cyc && m0_stb;
  assign req1 = m1_cyc && m1_stb;
  // On a tie the master that did not win last time gets the bus.
  assign win  = (req0 && req1) ? ~last_q : req1;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stage p1: request captured at grant, held for the whole BUSY phase
  always_ff @(posedge clock) begin
    if (grant) begin
      we_p1    <= win ? m1_we    : m0_we;
      adr_p1   <= win ? m1_adr   : m0_adr;
      datwr_p1 <= win ? m1_datwr : m0_datwr;
      sel_p1   <= win ? m1_sel   : m0_sel;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    grant       = 1'b0;
    timeout_hit = 1'b0;
    s_cyc       = 1'b0;
    s_stb       = 1'b0;
    s_abort     = 1'b0;
    m0_ack      = 1'b0;
    m1_ack      = 1'b0;
    m0_err      = 1'b0;
    m1_err      = 1'b0;
    m0_datrd    = '0;
    m1_datrd    = '0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant   = 1'b1;
          owner_d = win;
          last_d  = win;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        s_cyc       = 1'b1;
        s_stb       = 1'b1;
        cnt_d       = sat_inc(cnt_q);
        timeout_hit = (timeout_cycles != 0) && (cnt_q == TO_LAST) && !s_ack;
        // An ack for a master that already dropped cyc is swallowed here.
        if (s_ack) begin
          state_d = GAP;
          if (owner_q) begin
            m1_ack = m1_cyc;
            if (m1_cyc) m1_datrd = s_datrd;
          end else begin
            m0_ack = m0_cyc;
            if (m0_cyc) m0_datrd = s_datrd;
          end
        end else if (timeout_hit) begin
          state_d = GAP;
          s_abort = 1'b1;
          if (owner_q) m1_err = m1_cyc;
          else         m0_err = m0_cyc;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign vld_p1  = (state_q == BUSY);
  assign s_we    = vld_p1 & we_p1;
  assign s_adr   = vld_p1 ? adr_p1   : '0;
  assign s_datwr = vld_p1 ? datwr_p1 : '0;
  assign s_sel   = vld_p1 ? sel_p1   : '0;
  assign busy    = (state_q != IDLE);
  assign owner   = owner_q;

endmodule

// File: tb/tb_wb_uart_arbiter.sv
// Bench for wb_uart_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of grant order and completion outcome.
module tb_wb_uart_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 50;

  logic clock = 1'b0;
  logic reset = 1'b0;

  logic          cyc_t [2];
  logic          stb_t [2];
  logic          we_t  [2];
  logic [AW-1:0] adr_t [2];
  logic [DW-1:0] dat_t [2];
  logic [SW-1:0] sel_t [2];

  wire           m0_ack, m0_err, m1_ack, m1_err;
  wire  [DW-1:0] m0_datrd, m1_datrd;
  wire           s_cyc, s_stb, s_we, s_abort, busy, owner;
  wire  [AW-1:0] s_adr;
  wire  [DW-1:0] s_datwr;
  wire  [SW-1:0] s_sel;
  logic          s_ack;
  logic [DW-1:0] s_datrd;

  int n_chk = 0;
  int n_err = 0;
  int model_last;
  logic [AW-1:0] exp_adr;
  logic [DW-1:0] exp_dat;
  logic          exp_we;
  logic [SW-1:0] exp_sel;

  wb_uart_arbiter #(
    .addr_width(AW), .data_width(DW), .sel_width(SW), .timeout_cycles(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .m0_cyc(cyc_t[0]), .m0_stb(stb_t[0]), .m0_we(we_t[0]), .m0_adr(adr_t[0]),
    .m0_datwr(dat_t[0]), .m0_sel(sel_t[0]), .m0_ack(m0_ack), .m0_err(m0_err),
    .m0_datrd(m0_datrd),
    .m1_cyc(cyc_t[1]), .m1_stb(stb_t[1]), .m1_we(we_t[1]), .m1_adr(adr_t[1]),
    .m1_datwr(dat_t[1]), .m1_sel(sel_t[1]), .m1_ack(m1_ack), .m1_err(m1_err),
    .m1_datrd(m1_datrd),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_datwr(s_datwr),
    .s_sel(s_sel), .s_ack(s_ack), .s_datrd(s_datrd), .s_abort(s_abort),
    .busy(busy), .owner(owner)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  function automatic logic get_ack(input int m);
    return (m != 0) ? m1_ack : m0_ack;
  endfunction

  function automatic logic get_err(input int m);
    return (m != 0) ? m1_err : m0_err;
  endfunction

  function automatic logic [DW-1:0] get_rd(input int m);
    return (m != 0) ? m1_datrd : m0_datrd;
  endfunction

  task automatic set_req(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic w, input logic [SW-1:0] s);
    cyc_t[m] = 1'b1;
    stb_t[m] = 1'b1;
    adr_t[m] = a;
    dat_t[m] = d;
    we_t[m]  = w;
    sel_t[m] = s;
  endtask

  task automatic drop(input int m);
    cyc_t[m] = 1'b0;
    stb_t[m] = 1'b0;
  endtask

  // Model: sole requester wins; on a tie the master other than the last winner.
  function automatic int model_winner();
    logic r0, r1;
    r0 = cyc_t[0] && stb_t[0];
    r1 = cyc_t[1] && stb_t[1];
    if (r0 && r1) return 1 - model_last;
    return r0 ? 0 : 1;
  endfunction

  task automatic grant_expect(input int m);
    model_last = m;
    exp_adr = adr_t[m];
    exp_dat = dat_t[m];
    exp_we  = we_t[m];
    exp_sel = sel_t[m];
  endtask

  task automatic wait_stb(input int maxc, output int n);
    n = 0;
    do begin
      next_cycle();
      n++;
      @(negedge clock);
    end while (!s_stb && n < maxc);
    check_val("stb_rise", s_stb, 1);
  endtask

  task automatic quiet_outputs(input string tag);
    check_val({tag, "_ack"}, {m0_ack, m1_ack}, 0);
    check_val({tag, "_err"}, {m0_err, m1_err}, 0);
    check_val({tag, "_datrd"}, {m0_datrd, m1_datrd}, 0);
    check_val({tag, "_abort"}, s_abort, 0);
    check_val({tag, "_stb"}, {s_cyc, s_stb}, 0);
  endtask

  // Called at the negedge of BUSY cycle 1; returns at the negedge of the completion cycle.
  task automatic run_busy(input int w, input int c_ack, input logic [DW-1:0] rd,
                          input int drop_at, input bit scramble);
    int  c = 1;
    int  o = 1 - w;
    bit  done = 0;
    bit  on, ack_now, to_now;
    while (!done) begin
      on      = !(drop_at != 0 && c > drop_at);
      ack_now = (c == c_ack);
      to_now  = (c == TO) && !ack_now;
      check_val("busy_stb", {s_cyc, s_stb, busy}, 3'b111);
      check_val("owner", owner, w);
      check_val("s_adr", s_adr, exp_adr);
      check_val("s_datwr", s_datwr, exp_dat);
      check_val("s_we_sel", {s_we, s_sel}, {exp_we, exp_sel});
      check_val("own_ack", get_ack(w), ack_now && on);
      check_val("own_err", get_err(w), to_now && on);
      check_val("own_datrd", get_rd(w), (ack_now && on) ? rd : 32'h0);
      check_val("other_quiet", {get_ack(o), get_err(o), get_rd(o)}, 0);
      check_val("s_abort", s_abort, to_now);
      if (ack_now || to_now) begin
        done = 1;
      end else begin
        next_cycle();
        s_ack   = (c + 1 == c_ack);
        s_datrd = s_ack ? rd : DW'($urandom);
        if (drop_at == c) begin
          drop(w);
          adr_t[w] = ~adr_t[w];
        end
        if (scramble) begin
          adr_t[w] = AW'($urandom);
          dat_t[w] = DW'($urandom);
          we_t[w]  = 1'($urandom);
          sel_t[w] = SW'($urandom);
        end
        c++;
        @(negedge clock);
      end
    end
  endtask

  task automatic gap_check();
    @(negedge clock);
    check_val("gap_busy", busy, 1);
    quiet_outputs("gap");
  endtask

  task automatic idle_check();
    next_cycle();
    @(negedge clock);
    check_val("idle_busy", busy, 0);
    quiet_outputs("idle");
  endtask

  task automatic new_reqs();
    for (int m = 0; m < 2; m++)
      if (!cyc_t[m] && $urandom_range(0, 9) < 6)
        set_req(m, AW'($urandom), DW'($urandom), 1'($urandom), SW'($urandom));
    if (!cyc_t[0] && !cyc_t[1])
      set_req(int'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), 1'($urandom), SW'($urandom));
  endtask

  initial begin
    int n, w;
    for (int m = 0; m < 2; m++) begin
      cyc_t[m] = 0; stb_t[m] = 0; we_t[m] = 0;
      adr_t[m] = '0; dat_t[m] = '0; sel_t[m] = '0;
    end
    s_ack = 0;
    s_datrd = '0;
    model_last = 1;

    // Reset values
    reset = 0;
    repeat (2) next_cycle();
    reset = 1;
    @(negedge clock);
    quiet_outputs("rst");
    check_val("rst_state", {busy, owner, s_we, s_sel}, 0);
    check_val("rst_bus", {s_adr, s_datwr}, 0);

    // Single read, ack 40 cycles after s_stb rises
    next_cycle();
    set_req(0, 32'h10, 32'h0, 1'b0, 4'hF);
    grant_expect(model_winner());
    wait_stb(4, n);
    check_val("lat_first", n, 1);
    run_busy(0, 41, 32'hDEADBEEF, 0, 0);
    next_cycle(); s_ack = 0; drop(0);
    gap_check();
    idle_check();

    // Simultaneous requests straight after reset, then strict alternation
    next_cycle(); reset = 0;
    next_cycle(); reset = 1;
    model_last = 1;
    set_req(0, 32'h100, 32'h11, 1'b1, 4'h3);
    set_req(1, 32'h200, 32'h22, 1'b0, 4'hC);
    w = model_winner();
    check_val("sim_model_first", w, 0);
    grant_expect(w);
    wait_stb(4, n);
    run_busy(w, 4, 32'hA0A0A0A0, 0, 0);
    next_cycle(); s_ack = 0; drop(0);
    gap_check();
    grant_expect(model_winner());
    wait_stb(6, n);
    check_val("regrant_latency", n, 2);
    run_busy(1, 6, 32'hB1B1B1B1, 0, 0);
    next_cycle(); s_ack = 0; drop(1);
    set_req(0, 32'h300, 32'h33, 1'b0, 4'hF);
    gap_check();
    grant_expect(model_winner());
    wait_stb(6, n);
    check_val("third_latency", n, 2);
    run_busy(0, 3, 32'hC2C2C2C2, 0, 0);
    next_cycle(); s_ack = 0; drop(0);
    gap_check();

    // Timeout: bridge never acks
    next_cycle();
    set_req(0, 32'h44, 32'h0, 1'b0, 4'hF);
    grant_expect(model_winner());
    wait_stb(4, n);
    run_busy(0, 1000, 32'h0, 0, 0);
    next_cycle(); drop(0);
    gap_check();
    idle_check();

    // Abandon: m1 drops cyc after 5 BUSY cycles, late ack is swallowed
    next_cycle();
    set_req(1, 32'h55, 32'h5, 1'b1, 4'h1);
    grant_expect(model_winner());
    wait_stb(4, n);
    run_busy(1, 12, 32'h12345678, 5, 0);
    next_cycle(); s_ack = 0;
    gap_check();
    idle_check();

    // Ack arrives in the very cycle the timeout would fire
    next_cycle();
    set_req(0, 32'h66, 32'h6, 1'b0, 4'h2);
    grant_expect(model_winner());
    wait_stb(4, n);
    run_busy(0, TO, 32'hCAFEF00D, 0, 0);
    next_cycle(); s_ack = 0; drop(0);
    gap_check();
    idle_check();

    // Reset in the middle of BUSY
    next_cycle();
    set_req(0, 32'h77, 32'h7, 1'b1, 4'h8);
    grant_expect(model_winner());
    wait_stb(4, n);
    repeat (3) begin
      next_cycle();
      @(negedge clock);
      check_val("pre_rst_stb", s_stb, 1);
    end
    next_cycle(); reset = 0;
    @(negedge clock);
    next_cycle(); reset = 1;
    drop(0);
    set_req(1, 32'h88, 32'h8, 1'b0, 4'h4);
    model_last = 1;
    @(negedge clock);
    check_val("mid_rst_state", {s_cyc, s_stb, busy, owner}, 0);
    check_val("mid_rst_err", {m0_err, m1_err, s_abort}, 0);
    grant_expect(model_winner());
    wait_stb(4, n);
    check_val("post_rst_latency", n, 1);
    run_busy(1, 5, 32'h0BADC0DE, 0, 0);
    next_cycle(); s_ack = 0; drop(1);
    gap_check();

    // Randomized traffic
    next_cycle();
    new_reqs();
    for (int i = 0; i < 40; i++) begin
      w = model_winner();
      grant_expect(w);
      wait_stb(6, n);
      run_busy(w, int'($urandom_range(2, TO + 8)), DW'($urandom), 0, 1);
      next_cycle(); s_ack = 0; drop(w);
      new_reqs();
      gap_check();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/wb_uart_arbiter.md
Name: wb_uart_arbiter

Overview:
- Two-master round-robin Wishbone arbiter that shares a single UART Wishbone bridge (wb2uart) between two requesters, e.g. the copperv instruction and data buses.
- Captures the winning request, presents it to the bridge, and routes ack/data back to the owner.
- Enforces a transaction timeout and pulses an abort so the bridge can be reset.
- Sits between the core's bus masters and the wb2uart slave.

Parameters:
- addr_width, 32, Wishbone address width.
- data_width, 32, Wishbone data width.
- sel_width, data_width/8, byte-select width.
- timeout_cycles, 100000, maximum BUSY cycles without s_ack before abort; 0 disables the timeout.
- counter_width, $clog2(timeout_cycles+1), timeout counter width.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- m0_cyc, m0_stb, m0_we  input  1 each  master 0 Wishbone controls.
- m0_adr  input  addr_width  master 0 address.
- m0_datwr  input  data_width  master 0 write data.
- m0_sel  input  sel_width  master 0 byte selects.
- m0_ack, m0_err  output  1 each  master 0 completion / timeout error.
- m0_datrd  output  data_width  master 0 read data.
- m1_*  same set as m0_*  master 1.
- s_cyc, s_stb, s_we  output  1 each  to bridge.
- s_adr  output  addr_width  to bridge.
- s_datwr  output  data_width  to bridge.
- s_sel  output  sel_width  to bridge.
- s_ack  input  1  from bridge.
- s_datrd  input  data_width  from bridge.
- s_abort  output  1  one-cycle pulse on timeout, intended to drive the bridge reset.
- busy  output  1  high while state is not IDLE.
- owner  output  1  index of the current or last granted master.

Behaviour:
- States: IDLE, BUSY, GAP, held in a state register plus an owner register, a last-grant pointer and a timeout counter.
- Reset (reset==0 at a clock edge):
  - state=IDLE, owner=0, last=1 (so m0 wins the first tie), counter=0.
  - All outputs are 0 in the cycle after reset, including s_cyc, s_stb, s_abort, mX_ack, mX_err and datrd.
  - Reset mid-transaction drops s_stb immediately with no err and no abort.
- Request definition: reqX = mX_cyc && mX_stb.
- IDLE:
  - s_cyc = s_stb = 0.
  - If any req is high, choose a winner: the only requester, or when both request, the master != last.
  - At the edge: latch that master's we/adr/datwr/sel into registers, set owner=winner and last=winner, clear counter, go to BUSY.
  - If no request, stay IDLE.
- BUSY:
  - s_cyc = s_stb = 1.
  - s_we/s_adr/s_datwr/s_sel are driven from the latched registers, so they are stable even if the owner changes its bus.
  - Counter increments every cycle (saturating).
  - s_ack=1: the owner's ack = s_ack && owner_cyc and its datrd = s_datrd, both combinational in the same cycle. Go to GAP.
  - If the owner dropped cyc earlier, the ack is discarded: the transaction still completes on the bridge and the FSM still goes to GAP.
  - Timeout: timeout_cycles != 0, counter == timeout_cycles-1 and s_ack == 0.
    - The owner's err = owner_cyc and s_abort = 1, combinationally, for that cycle.
    - Go to GAP.
  - If s_ack and the timeout coincide, ack wins: no err, no abort.
- GAP:
  - Exactly one cycle; s_cyc = s_stb = 0; no ack or err.
  - Go to IDLE. This gives the bridge one idle cycle and gives the master time to drop stb.
- The non-owner master never sees ack or err; its datrd is 0.
- mX_datrd = 0 except during its forwarded ack.
- Latency:
  - Request first visible at edge N → s_stb high in cycle N+1.
  - Ack in cycle M → GAP in M+1, IDLE in M+2.
  - The earliest next grant has s_stb high in M+3.
- A master that keeps stb high through GAP is regranted as a new transaction; this is legal and treated as a new request.
- Fairness: with both masters requesting continuously, grants alternate strictly.
- No combinational path from mX_* to s_* (all s_* are registered).

Test Plan:
- Single read: m0 reads adr=0x10; bridge acks 40 cycles after s_stb with s_datrd=0xDEADBEEF → m0_ack pulses for one cycle with m0_datrd=0xDEADBEEF; m1_ack stays 0; s_stb=0 in the next cycle.
- Simultaneous: m0 and m1 assert in the same cycle after reset → m0 granted first (owner=0). After its ack and GAP, m1 granted with s_adr equal to m1's address; a third back-to-back m0 request follows in strict alternation.
- Timeout: timeout_cycles=50, bridge never acks → in BUSY cycle 50, m0_err=1 and s_abort=1 for exactly one cycle; busy falls 2 cycles later.
- Abandon: m1 drops cyc 5 cycles into BUSY while s_adr stays latched; s_ack arrives later → m1_ack stays 0 and the FSM passes through GAP to IDLE.
- Ack/timeout collision: s_ack arrives exactly in the timeout cycle → ack forwarded, err=0, s_abort=0.
- Reset mid-BUSY: reset=0 for 1 cycle → next cycle s_cyc=0, busy=0, owner=0; then m1 alone requests and is granted.
